// File: rtl/systolic_feeder_if.sv
// Write-side valid/ready port of the systolic feeder.
// One beat carries a full N-lane activation vector.
interface systolic_feeder_if #(
    parameter int DATA_W = 32,
    parameter int N      = 4
);
    logic                wr_valid;
    logic                wr_ready;
    logic [N*DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one NxN activation tile and streams it west-to-east
// into the systolic array with lane r delayed by r beats.
module systolic_feeder #(
    parameter int DATA_W = 32,
    parameter int N      = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    systolic_feeder_if.slave    wr,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [N*DATA_W-1:0] o_data,
    output logic [N-1:0]        o_valid
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (N > 1) ? $clog2(2*N-1) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N-1);
    localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_STREAM
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wr_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [TW-1:0]       r_t;
    logic [TW-1:0]       w_t_nxt;
    logic                w_beat_en;
    logic                w_done_nxt;
    logic                w_hs;
    logic [DATA_W-1:0]   r_buf [N][N];
    logic [TW-1:0]       w_k [N];
    logic [N*DATA_W-1:0] w_beat_data;
    logic [N-1:0]        w_beat_valid;

    logic                r_wr_ready;
    logic                r_busy;
    logic                r_done;
    logic [N*DATA_W-1:0] r_data;
    logic [N-1:0]        r_valid;

    assign w_hs        = wr.wr_valid && r_wr_ready;
    assign wr.wr_ready = r_wr_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_data      = r_data;
    assign o_valid     = r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wr_cnt <= '0;
            r_t      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_cnt_nxt;
            r_t      <= w_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wr_cnt;
        w_t_nxt     = r_t;
        w_beat_en   = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = (N == 1) ? S_LOADED : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    if (r_wr_cnt == C_LAST) begin
                        w_state_nxt = S_LOADED;
                    end else begin
                        w_cnt_nxt = r_wr_cnt + CW'(1);
                    end
                end
            end
            S_LOADED: begin
                if (i_start) begin
                    w_state_nxt = S_STREAM;
                    w_t_nxt     = '0;
                    w_beat_en   = 1'b1;
                end
            end
            S_STREAM: begin
                if (r_t == T_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_t_nxt     = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_t_nxt   = r_t + TW'(1);
                    w_beat_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lane r on beat t carries element r of vector t-r.
    always_comb begin
        w_beat_data  = '0;
        w_beat_valid = '0;
        for (int r = 0; r < N; r++) begin
            w_k[r] = w_t_nxt - TW'(r);
            if (w_beat_en && (w_t_nxt >= TW'(r))
                && (w_k[r] <= TW'(N-1))) begin
                w_beat_data[r*DATA_W +: DATA_W] = r_buf[w_k[r][CW-1:0]][r];
                w_beat_valid[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_hs) begin
            for (int r = 0; r < N; r++) begin
                r_buf[r_wr_cnt][r] <= wr.wr_data[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_valid    <= '0;
        end else begin
            r_wr_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_busy     <= (w_state_nxt == S_LOADED) || (w_state_nxt == S_STREAM);
            r_done     <= w_done_nxt;
            r_data     <= w_beat_data;
            r_valid    <= w_beat_valid;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a tile-level model predicts
// every streamed beat and done pulse with its cycle number.
module tb_systolic_feeder;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int W  = N*DW;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] data;
    logic [N-1:0] valid;

    systolic_feeder_if #(.DATA_W(DW), .N(N)) wr ();

    systolic_feeder #(.DATA_W(DW), .N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .wr      (wr),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .o_data  (data),
        .o_valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] v;
        bit           dn;
        int           cyc;
    } exp_t;

    typedef enum {M_LOAD, M_LOADED, M_STREAM} m_t;

    exp_t         sb[$];
    exp_t         me;
    exp_t         mo;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    m_t           mst = M_LOAD;
    int           mcnt = 0;
    int           mrem = 0;
    logic [W-1:0] tile [N];
    bit           b2b = 0;
    int           last_done = -1;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a tile is N accepted vectors; a start while
    // loaded schedules 2N-1 skewed beats and a done pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mst  = M_LOAD;
            mcnt = 0;
            mrem = 0;
            sb.delete();
        end else begin
            cyc++;
            case (mst)
                M_LOAD: begin
                    if (wr.wr_valid) begin
                        tile[mcnt] = wr.wr_data;
                        mcnt++;
                        if (mcnt == N) mst = M_LOADED;
                    end
                end
                M_LOADED: begin
                    if (start) begin
                        for (int t = 0; t < 2*N-1; t++) begin
                            me.d   = '0;
                            me.v   = '0;
                            me.dn  = 1'b0;
                            me.cyc = cyc + t;
                            for (int r = 0; r < N; r++) begin
                                if (t - r >= 0 && t - r < N) begin
                                    me.d[r*DW +: DW] = tile[t-r][r*DW +: DW];
                                    me.v[r] = 1'b1;
                                end
                            end
                            sb.push_back(me);
                        end
                        me.d   = '0;
                        me.v   = '0;
                        me.dn  = 1'b1;
                        me.cyc = cyc + 2*N - 1;
                        sb.push_back(me);
                        mst  = M_STREAM;
                        mrem = 2*N - 1;
                    end
                end
                default: begin
                    mrem--;
                    if (mrem == 0) begin
                        mst  = M_LOAD;
                        mcnt = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_ready", W'(wr.wr_ready), W'(mst == M_LOAD));
            chk("busy", W'(busy), W'(mst != M_LOAD));
            if (valid != '0 || done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output at cycle %0d: valid %b done %b",
                             cyc, valid, done);
                end else begin
                    mo = sb.pop_front();
                    chk("beat_cycle", W'(cyc), W'(mo.cyc));
                    chk("data", data, mo.d);
                    chk("valid", W'(valid), W'(mo.v));
                    chk("done", W'(done), W'(mo.dn));
                end
                if (done) begin
                    if (b2b && last_done >= 0)
                        chk("tile_period", W'(cyc - last_done), W'(12));
                    last_done = cyc;
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing output at cycle %0d: got none want cycle %0d",
                         cyc, sb[0].cyc);
                void'(sb.pop_front());
            end else begin
                chk("idle_data", data, '0);
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input bit s);
        wr.wr_valid = v;
        wr.wr_data  = d;
        start       = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] vec(input int base, input int k);
        logic [W-1:0] x;
        x = '0;
        for (int r = 0; r < N; r++) x[r*DW +: DW] = DW'(base + 16*k + r);
        return x;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] x;
        for (int r = 0; r < N; r++) x[r*DW +: DW] = $urandom;
        return x;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_wr_ready"}, W'(wr.wr_ready), W'(1));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_valid"}, W'(valid), W'(0));
        chk({tag, "_data"}, data, '0);
    endtask

    initial begin
        logic [W-1:0] v5;
        int           n;
        rst         = 1'b1;
        start       = 1'b0;
        wr.wr_valid = 1'b0;
        wr.wr_data  = '0;
        #2;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < N; k++) step(1'b1, vec(0, k), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(9);

        for (int k = 0; k < N; k++) step(1'b1, rnd(), 1'b0);
        v5 = rnd();
        step(1'b1, v5, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, v5, 1'b0);
        for (int k = 1; k < N; k++) step(1'b1, rnd(), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(9);

        step(1'b1, rnd(), 1'b0);
        step(1'b1, rnd(), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, rnd(), 1'b0);
        step(1'b1, rnd(), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(2);
        step(1'b0, '0, 1'b1);
        idle(8);

        for (int k = 0; k < N; k++) step(1'b1, rnd(), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < N; k++) step(1'b1, vec(32'hA0, k), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(9);

        b2b       = 1'b1;
        last_done = -1;
        for (int i = 0; i < 40; i++) step(1'b1, rnd(), 1'b1);
        b2b = 1'b0;
        idle(10);

        for (int i = 0; i < 300; i++)
            step($urandom_range(1, 0) == 1, rnd(), $urandom_range(3, 0) == 0);
        step(1'b0, '0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain_left", W'(sb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side skew feeder for the 4x4 systolic MAC array. It buffers one tile of activation vectors through a valid/ready write port. On command it streams the tile into the array's row inputs with the diagonal skew the MAC cells require: lane r is delayed r cycles. It sits between the activation memory/DMA and the west edge of the array. It is the producer for the data path that each MAC cell consumes and forwards east.

## Interface
- DATA_W, 32, width of one activation element
- N, 4, array dimension: number of lanes and vectors per tile
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_wr_valid  in  1  write vector offered
- o_wr_ready  out  1  feeder can accept a write vector
- i_wr_data  in  N*DATA_W  activation vector; lane r = bits [r*DATA_W +: DATA_W]
- i_start  in  1  begin streaming the loaded tile
- o_busy  out  1  high in LOADED and STREAM
- o_done  out  1  one-cycle pulse after the last streamed beat
- o_data  out  N*DATA_W  to array row inputs; lane r = bits [r*DATA_W +: DATA_W]
- o_valid  out  N  per-lane valid for o_data

## Operation
- Storage is buf[k][r], k = vector index 0..N-1, r = lane.
- A write handshake is i_wr_valid && o_wr_ready at a rising edge.
- States: IDLE, LOAD, LOADED, STREAM.
- IDLE, with wr_cnt=0:
  - o_wr_ready=1.
  - A handshake stores buf[0], sets wr_cnt=1 and moves to LOAD. With N=1 it moves directly to LOADED.
- LOAD:
  - o_wr_ready=1.
  - Each handshake stores buf[wr_cnt] and increments wr_cnt.
  - The handshake that writes index N-1 moves the block to LOADED.
- LOADED:
  - o_wr_ready=0.
  - i_start=1 at an edge moves the block to STREAM with beat counter t=0.
- STREAM:
  - t runs 0..2N-2, which is 7 beats for N=4.
  - On beat t, lane r presents buf[t-r][r] with o_valid[r]=1 when 0 <= t-r <= N-1. Otherwise it presents 0 with o_valid[r]=0.
  - After beat 2N-2 the block returns to IDLE, clears wr_cnt and pulses o_done.
- i_start is ignored in IDLE, LOAD and STREAM. It is not queued.
- Writes during LOADED or STREAM are refused (o_wr_ready=0), and buffer contents are unchanged.
- The buffer is not cleared on completion. The next tile overwrites it.
- Elements pass through unmodified. There is no arithmetic or width conversion.

## Timing
- All outputs are registered. Reset values:
  - o_wr_ready=1, o_busy=0, o_done=0, o_data=0, o_valid=0.
  - State is IDLE, wr_cnt=0, t=0.
- The write path accepts one vector per cycle at full throughput. A tile loads in N consecutive cycles.
- o_wr_ready falls in the cycle after the Nth handshake.
- Start latency:
  - Beat 0 appears on o_data/o_valid in the cycle immediately after the edge that samples i_start in LOADED.
  - Beat t appears t cycles later.
- In the cycle after beat 2N-2:
  - o_done=1 and o_busy=0.
  - o_valid=0 and o_data=0.
  - o_wr_ready=1.
- A write handshake may occur in the same cycle as o_done. It is accepted as vector 0 of the next tile.
- Minimum tile period is N load cycles + 1 start cycle + (2N-1) stream cycles, assuming i_start is held high and writes are back-to-back.
- o_busy is high from the cycle after the Nth handshake until the last beat, inclusive.
- Reset mid-operation, at any state:
  - Outputs return to their reset values asynchronously.
  - The partial tile is discarded. The next handshake after reset release writes buf[0].
- i_wr_valid may be held high with i_wr_data stable while o_wr_ready=0. No write occurs until o_wr_ready is 1.

## Test plan
- Reset:
  - Assert i_rst mid-cycle.
  - Outputs go to reset values without waiting for a clock edge: o_wr_ready=1, o_data=0, o_valid=0, o_done=0.
- Basic skew:
  - Load vectors k=0..3 with lane r = 16*k+r, for example vector 1 = {0x13,0x12,0x11,0x10}, then pulse i_start.
  - Beat 0: lane0=0x00, o_valid=0001.
  - Beat 3: lanes = {0x03,0x12,0x21,0x30}, o_valid=1111.
  - Beat 6: lane3=0x33, o_valid=1000.
  - o_done pulses in the cycle after beat 6.
- Backpressure:
  - Hold i_wr_valid=1 with a fifth vector after the 4th handshake.
  - o_wr_ready=0 and the buffer is unchanged; stream content matches the first four vectors.
  - The fifth vector is accepted in the o_done cycle as vector 0 of the next tile.
- Ignored start:
  - Pulse i_start after only 2 writes, and again mid-stream.
  - No state change, no restart; the stream remains exactly 7 beats.
- Reset mid-stream:
  - Assert i_rst at beat 3, release, load tile 0xA0..0xA3/… and start.
  - The stream contains only the new tile's values, and o_done appears exactly once.
- Back-to-back tiles:
  - Write continuously with i_start held high.
  - The tile period is 4+1+7=12 cycles, and o_valid patterns repeat 0001,0011,0111,1111,1110,1100,1000.
